// File: rtl/simple_bus_arbiter.sv
`default_nettype none
// ============================================================================
// simple_bus_arbiter : round-robin arbiter funnelling NUM_REQ requesters onto
//                      one simple memory bus, with a transfer timeout.
// Revision 1.0
// ============================================================================
module simple_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*8-1:0]   addr_i,
    input  logic [NUM_REQ*8-1:0]   data_i,
    input  logic [NUM_REQ*2-1:0]   mode_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic                   timeout_o,
    output logic                   busy_o,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic [7:0]             bus_addr,
    output logic [7:0]             bus_data,
    output logic [1:0]             bus_mode,
    output logic                   bus_start,
    input  logic                   bus_rdy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_XFER     = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [PTR_W-1:0]   ptr_q,       ptr_d;
    logic [PTR_W-1:0]   owner_q,     owner_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [NUM_REQ-1:0] done_q,      done_d;
    logic               timeout_q,   timeout_d;
    logic               busy_q,      busy_d;
    logic               bus_req_q,   bus_req_d;
    logic               bus_start_q, bus_start_d;
    logic [7:0]         bus_addr_q,  bus_addr_d;
    logic [7:0]         bus_data_q,  bus_data_d;
    logic [1:0]         bus_mode_q,  bus_mode_d;

    logic [7:0]         addr_arr [NUM_REQ];
    logic [7:0]         data_arr [NUM_REQ];
    logic [1:0]         mode_arr [NUM_REQ];

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;

    genvar gk;
    generate
        for (gk = 0; gk < NUM_REQ; gk++) begin : g_unpack
            assign addr_arr[gk] = addr_i[8*gk +: 8];
            assign data_arr[gk] = data_i[8*gk +: 8];
            assign mode_arr[gk] = mode_i[2*gk +: 2];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        return (idx == IDX_LAST) ? '0 : idx + PTR_W'(1);
    endfunction

    // Scan from the round-robin pointer, wrapping at NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        timeout_d   = 1'b0;
        bus_req_d   = bus_req_q;
        bus_start_d = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        bus_mode_d  = bus_mode_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_WAIT_GNT;
                    owner_d          = win_idx;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    bus_req_d        = 1'b1;
                    bus_addr_d       = addr_arr[win_idx];
                    bus_data_d       = data_arr[win_idx];
                    bus_mode_d       = mode_arr[win_idx];
                end
            end
            ST_WAIT_GNT: begin
                if (bus_gnt) begin
                    state_d     = ST_XFER;
                    cnt_d       = '0;
                    bus_start_d = 1'b1;
                end
            end
            ST_XFER: begin
                // Ready takes priority over an expiring counter in the same cycle.
                if (bus_rdy || (cnt_q == CNT_LAST)) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    bus_req_d = 1'b0;
                    ptr_d     = next_idx(owner_q);
                    if (bus_rdy) begin
                        done_d = gnt_q;
                    end else begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_d     = '0;
                bus_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_start_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            bus_mode_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            bus_req_q   <= bus_req_d;
            bus_start_q <= bus_start_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            bus_mode_q  <= bus_mode_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;
    assign busy_o    = busy_q;
    assign bus_req   = bus_req_q;
    assign bus_start = bus_start_q;
    assign bus_addr  = bus_addr_q;
    assign bus_data  = bus_data_q;
    assign bus_mode  = bus_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_simple_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_simple_bus_arbiter : directed and randomized checks of simple_bus_arbiter
//                         against a transaction-level reference model.
// Revision 1.0
// ============================================================================
module tb_simple_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_i = '0;
    logic [N*8-1:0]   addr_i = '0;
    logic [N*8-1:0]   data_i = '0;
    logic [N*2-1:0]   mode_i = '0;
    logic             bus_gnt = 1'b0;
    logic             bus_rdy = 1'b0;
    logic [N-1:0]     gnt_o, done_o;
    logic             timeout_o, busy_o, bus_req, bus_start;
    logic [7:0]       bus_addr, bus_data;
    logic [1:0]       bus_mode;

    simple_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .mode_i    (mode_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .timeout_o (timeout_o),
        .busy_o    (busy_o),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_mode  (bus_mode),
        .bus_start (bus_start),
        .bus_rdy   (bus_rdy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an owner index (-1 = bus free), whether the memory
    // side has granted, and how many transfer cycles have elapsed.
    int           m_owner;
    bit           m_started;
    int           m_elapsed;
    int           m_ptr;
    logic [N-1:0] e_gnt, e_done;
    logic         e_to, e_busy, e_breq, e_bstart;
    logic [7:0]   e_addr, e_data;
    logic [1:0]   e_mode;

    task automatic model_reset();
        m_owner = -1; m_started = 0; m_elapsed = 0; m_ptr = 0;
        e_gnt = '0; e_done = '0; e_to = 0; e_busy = 0; e_breq = 0; e_bstart = 0;
        e_addr = '0; e_data = '0; e_mode = '0;
    endtask

    task automatic release_owner(input bit by_timeout);
        if (by_timeout) e_to = 1'b1;
        else            e_done[m_owner] = 1'b1;
        e_gnt = '0; e_breq = 0; e_busy = 0;
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    task automatic model_edge();
        e_done = '0; e_to = 0; e_bstart = 0;
        if (m_owner < 0) begin
            if (req_i != '0) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr + i) % N;
                    if (m_owner < 0 && req_i[k]) m_owner = k;
                end
                e_gnt = '0; e_gnt[m_owner] = 1'b1;
                e_breq = 1; e_busy = 1; m_started = 0;
                e_addr = addr_i[8*m_owner +: 8];
                e_data = data_i[8*m_owner +: 8];
                e_mode = mode_i[2*m_owner +: 2];
            end
        end else if (!m_started) begin
            if (bus_gnt) begin
                m_started = 1; m_elapsed = 0; e_bstart = 1;
            end
        end else begin
            m_elapsed++;
            if (bus_rdy)              release_owner(1'b0);
            else if (m_elapsed == TO) release_owner(1'b1);
        end
    endtask

    task automatic compare_all();
        check_val("gnt_o",     32'(gnt_o),     32'(e_gnt));
        check_val("done_o",    32'(done_o),    32'(e_done));
        check_val("timeout_o", 32'(timeout_o), 32'(e_to));
        check_val("busy_o",    32'(busy_o),    32'(e_busy));
        check_val("bus_req",   32'(bus_req),   32'(e_breq));
        check_val("bus_start", 32'(bus_start), 32'(e_bstart));
        check_val("bus_addr",  32'(bus_addr),  32'(e_addr));
        check_val("bus_data",  32'(bus_data),  32'(e_data));
        check_val("bus_mode",  32'(bus_mode),  32'(e_mode));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_xfer(input logic [N-1:0] r, input logic [N-1:0] r_after,
                            input int gnt_dly, input int rdy_dly,
                            output logic [N-1:0] g_seen, output logic [N-1:0] d_seen,
                            output logic t_seen, output int t_lat);
        req_i = r; bus_gnt = 0; bus_rdy = 0;
        step();
        g_seen = gnt_o;
        req_i = r_after;
        repeat (gnt_dly) step();
        bus_gnt = 1;
        step();
        bus_gnt = 0;
        d_seen = '0; t_seen = 0; t_lat = 0;
        if (rdy_dly >= 0) begin
            repeat (rdy_dly) begin
                step();
                d_seen |= done_o; t_seen |= timeout_o;
            end
            bus_rdy = 1;
            step();
            bus_rdy = 0;
            d_seen |= done_o; t_seen |= timeout_o;
        end else begin
            for (int j = 1; j <= TO + 4; j++) begin
                step();
                if (timeout_o && t_lat == 0) t_lat = j;
                d_seen |= done_o; t_seen |= timeout_o;
                if (t_seen) break;
            end
        end
    endtask

    task automatic async_reset();
        rst_n = 0;
        #1;
        model_reset();
        compare_all();
        step();
        rst_n = 1;
    endtask

    logic [N-1:0] g, d;
    logic         t;
    int           lat;
    logic [N-1:0] rr_exp [5];

    initial begin
        model_reset();
        #2;
        async_reset();

        // Round-robin order with every requester asserted
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            addr_i = $urandom; data_i = $urandom; mode_i = 8'($urandom);
            run_xfer(4'b1111, 4'b1111, 0, 1, g, d, t, lat);
            check_val("rr_grant", 32'(g), 32'(rr_exp[i]));
            check_val("rr_done",  32'(d), 32'(rr_exp[i]));
        end

        // Single requester 1 with a known address
        addr_i = 32'h0000_3C00;
        run_xfer(4'b0010, 4'b0000, 1, 2, g, d, t, lat);
        check_val("single_gnt",  32'(g), 32'h2);
        check_val("single_addr", 32'(bus_addr), 32'h3C);
        check_val("single_done", 32'(d), 32'h2);
        check_val("single_to",   32'(t), 32'h0);

        // Pointer now at 2; no ready, so the transfer must time out
        run_xfer(4'b1111, 4'b0000, 0, -1, g, d, t, lat);
        check_val("to_gnt",     32'(g), 32'h4);
        check_val("to_pulse",   32'(t), 32'h1);
        check_val("to_latency", 32'(lat), 32'(TO));
        check_val("to_nodone",  32'(d), 32'h0);
        check_val("to_release", 32'(gnt_o), 32'h0);
        check_val("to_idle",    32'(busy_o), 32'h0);

        // Ready on the last permitted cycle wins over the timeout
        run_xfer(4'b1111, 4'b0000, 0, TO - 1, g, d, t, lat);
        check_val("edge_gnt",  32'(g), 32'h8);
        check_val("edge_done", 32'(d), 32'h8);
        check_val("edge_to",   32'(t), 32'h0);

        // Owner withdraws its request while waiting for the bus
        run_xfer(4'b0010, 4'b0000, 3, 1, g, d, t, lat);
        check_val("drop_gnt",  32'(g), 32'h2);
        check_val("drop_done", 32'(d), 32'h2);

        // Reset in the middle of a transfer
        req_i = 4'b0100;
        step();
        req_i = '0; bus_gnt = 1;
        step();
        bus_gnt = 0;
        step(); step();
        async_reset();
        req_i = 4'b1001;
        step();
        check_val("post_rst_gnt", 32'(gnt_o), 32'h1);
        req_i = '0; bus_gnt = 1;
        step();
        bus_gnt = 0; bus_rdy = 1;
        step();
        bus_rdy = 0;
        step();

        // Randomized traffic
        begin
            bit slow;
            slow = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c % 64 == 0) slow = ($urandom_range(0, 2) == 0);
                req_i   = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
                addr_i  = $urandom;
                data_i  = $urandom;
                mode_i  = 8'($urandom);
                bus_gnt = ($urandom_range(0, 2) == 0);
                bus_rdy = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 499) == 0) async_reset();
                else                             step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
